// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU-to-RAM/MMIO bus controller with cmd/ready handshake
//
// Purpose: accepts one CPU access at a time, absorbs the RAM's 1-cycle read
// latency, decodes the LED (0x100) and switch (0x140) registers, latches HALT.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   mem_cmd/mem_addr        CPU request (01 read, 10 write, others idle)
//   write_data, read_data   CPU store/load data
//   mem_ready               one-cycle completion pulse
//   halt                    CPU HALT state indication
//   sw                      raw switch inputs
//   ram_addr/ram_we/ram_wdata/ram_rdata   synchronous RAM port
//   led, halt_led           LEDR[7:0] register, LEDR[8] sticky halt flag
//   bus_err                 sticky unmapped-access flag
module mem_bus_ctrl #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     write_data,
  output logic [DW-1:0]     read_data,
  output logic              mem_ready,
  input  logic              halt,
  input  logic [7:0]        sw,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic [7:0]        led,
  output logic              halt_led,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;

  localparam logic [AW-1:0] LED_ADDR = AW'(9'h100);
  localparam logic [AW-1:0] SW_ADDR  = AW'(9'h140);

  state_t        state_q, state_d;
  logic [DW-1:0] read_data_q, read_data_d;
  logic          mem_ready_q, mem_ready_d;
  logic [7:0]    led_q, led_d;
  logic          halt_led_q, halt_led_d;
  logic          bus_err_q, bus_err_d;
  logic [7:0]    sw_sync1_q, sw_sync1_d;
  logic [7:0]    sw_sync2_q, sw_sync2_d;

  logic cmd_rd, cmd_wr, is_ram, is_led, is_sw, is_unmapped, is_idle;

  assign cmd_rd      = (mem_cmd == 2'b01);
  assign cmd_wr      = (mem_cmd == 2'b10);
  assign is_ram      = ~mem_addr[AW-1];
  assign is_led      = (mem_addr == LED_ADDR);
  assign is_sw       = (mem_addr == SW_ADDR);
  assign is_unmapped = ~is_ram & ~is_led & ~is_sw;
  assign is_idle     = (state_q == IDLE);

  // The RAM port is driven straight from the request in the sampling cycle so
  // the synchronous RAM captures the address on the same edge the FSM does;
  // read data is then available for RD_WAIT one edge later. Writes are gated
  // by reset so a request held through reset never reaches the RAM.
  assign ram_addr  = mem_addr[RAM_AW-1:0];
  assign ram_wdata = write_data;
  assign ram_we    = reset_n & is_idle & cmd_wr & is_ram & ~halt_led_q;

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    mem_ready_d = 1'b0;
    led_d       = led_q;
    halt_led_d  = halt_led_q | halt;
    bus_err_d   = bus_err_q;
    sw_sync1_d  = sw;
    sw_sync2_d  = sw_sync1_q;

    case (state_q)
      IDLE: begin
        if (cmd_rd) begin
          if (is_ram) begin
            state_d = RD_WAIT;
          end else begin
            if (is_sw) begin
              read_data_d = {{(DW-8){1'b0}}, sw_sync2_q};
            end else if (is_led) begin
              read_data_d = {{(DW-8){1'b0}}, led_q};
            end else begin
              read_data_d = '0;
            end
            state_d = DONE;
          end
          if (is_unmapped) bus_err_d = 1'b1;
        end else if (cmd_wr) begin
          // Once halted, writes still handshake but leave no side effect.
          if (is_led && !halt_led_q) led_d = write_data[7:0];
          if (is_unmapped) bus_err_d = 1'b1;
          state_d = DONE;
        end
      end
      RD_WAIT: begin
        read_data_d = ram_rdata;
        state_d     = DONE;
      end
      DONE: begin
        // Ready is registered here, so it is seen in the cycle after DONE.
        mem_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      led_q       <= 8'h00;
      halt_led_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      sw_sync1_q  <= 8'h00;
      sw_sync2_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      led_q       <= led_d;
      halt_led_q  <= halt_led_d;
      bus_err_q   <= bus_err_d;
      sw_sync1_q  <= sw_sync1_d;
      sw_sync2_q  <= sw_sync2_d;
    end
  end

  assign read_data = read_data_q;
  assign mem_ready = mem_ready_q;
  assign led       = led_q;
  assign halt_led  = halt_led_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        halt;
  logic [7:0]  sw;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  led;
  logic        halt_led;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .halt       (halt),
    .sw         (sw),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .led        (led),
    .halt_led   (halt_led),
    .bus_err    (bus_err)
  );

  // Synchronous RAM with a side port for preloading contents.
  logic [15:0] ram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h00;
  logic [15:0] pre_data = 16'h0000;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int we_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Called at a negedge; returns the number of posedges from sampling to ready.
  task automatic access(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                        output int l);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
    @(negedge clk);
    mem_cmd = 2'b00;
    l = 1;
    while (mem_ready !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    mem_cmd    = 2'b00;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    halt       = 1'b0;
    sw         = 8'h00;
    @(negedge clk);
    preload(8'h14, 16'd850);
    preload(8'h20, 16'h0000);

    // Reset held for 2 clocks with a read pending.
    mem_cmd  = 2'b01;
    mem_addr = 9'h014;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_led", led, 8'h00);
    chk("rst_halt_led", halt_led, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_read_data", read_data, 16'h0000);
    mem_cmd    = 2'b10;
    mem_addr   = 9'h030;
    write_data = 16'hDEAD;
    #1;
    chk("rst_write_gated", ram_we, 1'b0);
    @(negedge clk);
    mem_cmd = 2'b00;
    reset_n = 1'b1;
    @(negedge clk);

    // RAM read: ready exactly 3 clocks after sampling.
    access(2'b01, 9'h014, 16'h0000, lat);
    chk("rd_latency", lat, 3);
    chk("rd_data", read_data, 16'd850);
    @(negedge clk);
    chk("rd_ready_pulse", mem_ready, 1'b0);
    chk("rd_data_hold", read_data, 16'd850);

    // RAM write: one-cycle we, ready on the following clock.
    mem_cmd    = 2'b10;
    mem_addr   = 9'h015;
    write_data = 16'hBADD;
    #1;
    chk("wr_we", ram_we, 1'b1);
    chk("wr_addr", ram_addr, 8'h15);
    @(negedge clk);
    mem_cmd = 2'b00;
    #1;
    chk("wr_we_off", ram_we, 1'b0);
    chk("wr_ready_early", mem_ready, 1'b0);
    @(negedge clk);
    chk("wr_ready", mem_ready, 1'b1);
    chk("wr_ram", ram[8'h15], 16'hBADD);
    @(negedge clk);

    // MMIO: LED write and readback, synchronized switch read.
    access(2'b10, 9'h100, 16'h00A5, lat);
    chk("led_wr_latency", lat, 2);
    chk("led_value", led, 8'hA5);
    @(negedge clk);
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    access(2'b01, 9'h140, 16'h0000, lat);
    chk("sw_latency", lat, 2);
    chk("sw_read", read_data, 16'h003C);
    @(negedge clk);
    access(2'b01, 9'h100, 16'h0000, lat);
    chk("led_read", read_data, 16'h00A5);
    chk("no_bus_err_yet", bus_err, 1'b0);
    @(negedge clk);

    // Reserved command: no completion, no error.
    mem_cmd  = 2'b11;
    mem_addr = 9'h1FF;
    repeat (3) begin
      @(negedge clk);
      chk("rsv_no_ready", mem_ready, 1'b0);
    end
    mem_cmd = 2'b00;
    chk("rsv_no_bus_err", bus_err, 1'b0);
    @(negedge clk);

    // Unmapped read.
    access(2'b01, 9'h1FF, 16'h0000, lat);
    chk("unm_latency", lat, 2);
    chk("unm_data", read_data, 16'h0000);
    chk("unm_bus_err", bus_err, 1'b1);
    @(negedge clk);

    // Halt pulse, then writes complete with no side effect.
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_led_set", halt_led, 1'b1);
    access(2'b10, 9'h100, 16'h00FF, lat);
    chk("halt_wr_latency", lat, 2);
    chk("halt_led_frozen", led, 8'hA5);
    @(negedge clk);
    we_base = we_cnt;
    access(2'b10, 9'h020, 16'h1234, lat);
    chk("halt_ram_latency", lat, 2);
    chk("halt_no_we", we_cnt - we_base, 0);
    chk("halt_ram_kept", ram[8'h20], 16'h0000);
    chk("halt_led_hold", halt_led, 1'b1);
    @(negedge clk);

    // Reset during RD_WAIT abandons the read.
    mem_cmd  = 2'b01;
    mem_addr = 9'h014;
    @(negedge clk);
    mem_cmd = 2'b00;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      chk("midrst_no_ready", mem_ready, 1'b0);
      @(negedge clk);
    end
    chk("midrst_halt_led", halt_led, 1'b0);
    chk("midrst_bus_err", bus_err, 1'b0);
    chk("midrst_led", led, 8'h00);
    chk("midrst_read_data", read_data, 16'h0000);
    access(2'b01, 9'h015, 16'h0000, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_data", read_data, 16'hBADD);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
